// File: rtl/idli_uart_cfg_m.sv
// Full-duplex UART bridging 4b nibble streams to serial TX/RX lines, widths and timing set by parameters.
// Latency: start bit the cycle after the last TX nibble is accepted; RX nibbles follow the stop sample by 1 cycle.
// Backpressure: TX accept drops while a frame is on the line; RX has none (a busy holding buffer drops frames).
module idli_uart_cfg_m #(
  parameter int DATA_BITS = 8,
  parameter int CLK_DIV   = 4,
  parameter int STOP_BITS = 1
) (
  input  logic       i_uart_gck,
  input  logic       i_uart_rst_n,
  input  logic [3:0] i_uart_tx,
  input  logic       i_uart_tx_vld,
  output logic       o_uart_tx_acp,
  output logic       o_uart_tx,
  input  logic       i_uart_rx,
  output logic [3:0] o_uart_rx,
  output logic       o_uart_rx_vld,
  output logic       o_uart_rx_err,
  output logic       o_uart_rx_ovf
);
  localparam int NIB = DATA_BITS / 4;
  localparam int TW  = $clog2(CLK_DIV + 1);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam int NW  = $clog2(NIB + 1);
  localparam logic [TW-1:0] TMR_LAST  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TMR_HALF  = TW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [NW-1:0] NIB_LAST  = NW'(NIB - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_STOP} tx_st_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_e;

  tx_st_e               tx_st_q, tx_st_d;
  logic [TW-1:0]        tx_tmr_q, tx_tmr_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [NW-1:0]        tx_nib_q, tx_nib_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_bnd;

  assign tx_bnd = (tx_tmr_q == TMR_LAST);

  always_comb begin
    tx_st_d       = tx_st_q;
    tx_tmr_d      = tx_bnd ? '0 : tx_tmr_q + 1'b1;
    tx_bit_d      = tx_bit_q;
    tx_nib_d      = tx_nib_q;
    tx_sh_d       = tx_sh_q;
    o_uart_tx_acp = 1'b0;
    o_uart_tx     = 1'b1;
    case (tx_st_q)
      TX_IDLE: begin
        o_uart_tx_acp = 1'b1;
        tx_tmr_d      = '0;
        if (i_uart_tx_vld) begin
          tx_sh_d[3:0] = i_uart_tx;
          tx_nib_d     = NW'(1);
          tx_st_d      = (NIB == 1) ? TX_START : TX_LOAD;
        end
      end
      TX_LOAD: begin
        o_uart_tx_acp = 1'b1;
        tx_tmr_d      = '0;
        if (i_uart_tx_vld) begin
          tx_sh_d[tx_nib_q*4 +: 4] = i_uart_tx;
          if (tx_nib_q == NIB_LAST) tx_st_d = TX_START;
          else                      tx_nib_d = tx_nib_q + 1'b1;
        end
      end
      TX_START: begin
        o_uart_tx = 1'b0;
        if (tx_bnd) begin
          tx_st_d  = TX_DATA;
          tx_bit_d = '0;
        end
      end
      TX_DATA: begin
        o_uart_tx = tx_sh_q[0];
        if (tx_bnd) begin
          tx_sh_d = tx_sh_q >> 1;
          if (tx_bit_q == BIT_LAST) begin
            tx_st_d  = TX_STOP;
            tx_bit_d = '0;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (tx_bnd) begin
          if (tx_bit_q == STOP_LAST) begin
            tx_st_d  = TX_IDLE;
            tx_bit_d = '0;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
      end
      default: tx_st_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge i_uart_gck or negedge i_uart_rst_n) begin
    if (!i_uart_rst_n) begin
      tx_st_q  <= TX_IDLE;
      tx_tmr_q <= '0;
      tx_bit_q <= '0;
      tx_nib_q <= '0;
      tx_sh_q  <= '0;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_tmr_q <= tx_tmr_d;
      tx_bit_q <= tx_bit_d;
      tx_nib_q <= tx_nib_d;
      tx_sh_q  <= tx_sh_d;
    end
  end

  rx_st_e               rx_st_q, rx_st_d;
  logic [1:0]           rx_sync_q, rx_sync_d;
  logic [TW-1:0]        rx_tmr_q, rx_tmr_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_arm_q, rx_arm_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic [NW-1:0]        hold_cnt_q, hold_cnt_d;
  logic                 hold_busy_q, hold_busy_d;
  logic                 err_q, err_d, ovf_q, ovf_d;
  logic                 rx_s;

  assign rx_s = rx_sync_q[1];

  always_comb begin
    rx_sync_d   = {rx_sync_q[0], i_uart_rx};
    rx_st_d     = rx_st_q;
    rx_tmr_d    = rx_tmr_q + 1'b1;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_arm_d    = rx_arm_q;
    hold_d      = hold_q;
    hold_cnt_d  = hold_cnt_q;
    hold_busy_d = hold_busy_q;
    err_d       = 1'b0;
    ovf_d       = 1'b0;
    if (hold_busy_q) begin
      hold_d = hold_q >> 4;
      if (hold_cnt_q == NIB_LAST) begin
        hold_busy_d = 1'b0;
        hold_cnt_d  = '0;
      end else begin
        hold_cnt_d  = hold_cnt_q + 1'b1;
      end
    end
    case (rx_st_q)
      RX_IDLE: begin
        rx_tmr_d = '0;
        // After a framing error the line must return high before a new start counts
        if (rx_s)          rx_arm_d = 1'b1;
        else if (rx_arm_q) rx_st_d  = RX_START;
      end
      RX_START: begin
        if (rx_tmr_q == TMR_HALF) begin
          rx_tmr_d = '0;
          rx_bit_d = '0;
          rx_st_d  = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_tmr_q == TMR_LAST) begin
          rx_tmr_d = '0;
          rx_sh_d  = {rx_s, rx_sh_q[DATA_BITS-1:1]};
          if (rx_bit_q == BIT_LAST) rx_st_d  = RX_STOP;
          else                      rx_bit_d = rx_bit_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_tmr_q == TMR_LAST) begin
          rx_tmr_d = '0;
          rx_st_d  = RX_IDLE;
          if (!rx_s) begin
            err_d    = 1'b1;
            rx_arm_d = 1'b0;
          end else if (hold_busy_q) begin
            ovf_d = 1'b1;
          end else begin
            hold_d      = rx_sh_q;
            hold_busy_d = 1'b1;
            hold_cnt_d  = '0;
          end
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_uart_gck or negedge i_uart_rst_n) begin
    if (!i_uart_rst_n) begin
      rx_st_q     <= RX_IDLE;
      rx_sync_q   <= 2'b11;
      rx_tmr_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      rx_arm_q    <= 1'b1;
      hold_q      <= '0;
      hold_cnt_q  <= '0;
      hold_busy_q <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      rx_st_q     <= rx_st_d;
      rx_sync_q   <= rx_sync_d;
      rx_tmr_q    <= rx_tmr_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      rx_arm_q    <= rx_arm_d;
      hold_q      <= hold_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_busy_q <= hold_busy_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign o_uart_rx     = hold_q[3:0];
  assign o_uart_rx_vld = hold_busy_q;
  assign o_uart_rx_err = err_q;
  assign o_uart_rx_ovf = ovf_q;
endmodule

// File: tb/tb_idli_uart_cfg_m.sv
// Bench for idli_uart_cfg_m: an 8-bit/div-4/1-stop instance and a 16-bit/div-2/2-stop loopback instance.
module tb_idli_uart_cfg_m;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [3:0] tx8_dat, rx8_dat, tx16_dat, rx16_dat;
  logic tx8_vld, tx8_acp, tx8_line, rx8_line, rx8_drv, loop8;
  logic rx8_vld, rx8_err, rx8_ovf;
  logic tx16_vld, tx16_acp, tx16_line, rx16_vld, rx16_err, rx16_ovf;

  assign rx8_line = loop8 ? tx8_line : rx8_drv;

  idli_uart_cfg_m #(.DATA_BITS(8), .CLK_DIV(4), .STOP_BITS(1)) dut8 (
    .i_uart_gck(clk), .i_uart_rst_n(rst_n),
    .i_uart_tx(tx8_dat), .i_uart_tx_vld(tx8_vld), .o_uart_tx_acp(tx8_acp), .o_uart_tx(tx8_line),
    .i_uart_rx(rx8_line), .o_uart_rx(rx8_dat), .o_uart_rx_vld(rx8_vld),
    .o_uart_rx_err(rx8_err), .o_uart_rx_ovf(rx8_ovf));

  idli_uart_cfg_m #(.DATA_BITS(16), .CLK_DIV(2), .STOP_BITS(2)) dut16 (
    .i_uart_gck(clk), .i_uart_rst_n(rst_n),
    .i_uart_tx(tx16_dat), .i_uart_tx_vld(tx16_vld), .o_uart_tx_acp(tx16_acp), .o_uart_tx(tx16_line),
    .i_uart_rx(tx16_line), .o_uart_rx(rx16_dat), .o_uart_rx_vld(rx16_vld),
    .o_uart_rx_err(rx16_err), .o_uart_rx_ovf(rx16_ovf));

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp8[$];
  logic [3:0] exp16[$];
  logic [3:0] obs8[256];
  logic [3:0] obs16[256];
  int wr8 = 0, wr16 = 0, rd8 = 0, rd16 = 0;
  int err8 = 0, ovf8 = 0, err16 = 0, ovf16 = 0;

  // Capture everything the DUTs emit; the tests consume it in order.
  always @(negedge clk) begin
    if (rx8_vld) begin obs8[wr8 % 256] <= rx8_dat; wr8 <= wr8 + 1; end
    if (rx16_vld) begin obs16[wr16 % 256] <= rx16_dat; wr16 <= wr16 + 1; end
    if (rx8_err) err8 <= err8 + 1;
    if (rx8_ovf) ovf8 <= ovf8 + 1;
    if (rx16_err) err16 <= err16 + 1;
    if (rx16_ovf) ovf16 <= ovf16 + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] b);
    int c;
    for (int i = 0; i < 2; i++) begin
      tx8_dat = b[i*4 +: 4];
      tx8_vld = 1'b1;
      @(negedge clk);
      c = 0;
      while (!tx8_acp && c < 200) begin @(negedge clk); c++; end
      if (!tx8_acp) begin
        n_cmp++; n_bad++;
        $display("FAIL send8_acp_timeout got acp=%b want 1", tx8_acp);
      end
      @(posedge clk); #1;
    end
    tx8_vld = 1'b0;
  endtask

  task automatic send16(input logic [15:0] w);
    int c;
    for (int i = 0; i < 4; i++) begin
      tx16_dat = w[i*4 +: 4];
      tx16_vld = 1'b1;
      @(negedge clk);
      c = 0;
      while (!tx16_acp && c < 200) begin @(negedge clk); c++; end
      if (!tx16_acp) begin
        n_cmp++; n_bad++;
        $display("FAIL send16_acp_timeout got acp=%b want 1", tx16_acp);
      end
      @(posedge clk); #1;
    end
    tx16_vld = 1'b0;
  endtask

  task automatic drive_rx8(input logic [7:0] b, input logic stop);
    rx8_drv = 1'b0; tick(4);
    for (int i = 0; i < 8; i++) begin rx8_drv = b[i]; tick(4); end
    rx8_drv = stop; tick(4);
    rx8_drv = 1'b1; tick(8);
  endtask

  task automatic wait_obs8(input int budget);
    int c = 0;
    while ((wr8 - rd8) < exp8.size() && c < budget) begin @(negedge clk); c++; end
    if ((wr8 - rd8) < exp8.size()) begin
      n_cmp++; n_bad++;
      $display("FAIL rx8_drain_timeout got %0d nibbles want %0d", wr8 - rd8, exp8.size());
    end
    tick(1);
  endtask

  task automatic wait_obs16(input int budget);
    int c = 0;
    while ((wr16 - rd16) < exp16.size() && c < budget) begin @(negedge clk); c++; end
    if ((wr16 - rd16) < exp16.size()) begin
      n_cmp++; n_bad++;
      $display("FAIL rx16_drain_timeout got %0d nibbles want %0d", wr16 - rd16, exp16.size());
    end
    tick(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tx8_line, tx8_acp, rx8_vld, rx8_err, rx8_ovf} !== 5'b11000) begin
      n_bad++; $display("FAIL reset8_outputs got %b want 11000", {tx8_line, tx8_acp, rx8_vld, rx8_err, rx8_ovf});
    end
    n_cmp++;
    if ({tx16_line, tx16_acp, rx16_vld, rx16_err, rx16_ovf} !== 5'b11000) begin
      n_bad++; $display("FAIL reset16_outputs got %b want 11000", {tx16_line, tx16_acp, rx16_vld, rx16_err, rx16_ovf});
    end
    tick(3);
    rst_n = 1'b1;
    tick(4);
    n_cmp++;
    if ({tx8_line, tx8_acp, rx8_vld, rx8_err, rx8_ovf} !== 5'b11000) begin
      n_bad++; $display("FAIL idle8_outputs got %b want 11000", {tx8_line, tx8_acp, rx8_vld, rx8_err, rx8_ovf});
    end
  endtask

  task automatic test_tx_a5();
    logic [7:0] b = 8'hA5;
    logic e;
    loop8 = 1'b0;
    rx8_drv = 1'b1;
    send8(b);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      e = (k < 4) ? 1'b0 : (k < 36) ? b[k/4 - 1] : 1'b1;
      n_cmp++;
      if (tx8_line !== e) begin
        n_bad++; $display("FAIL tx_a5_line cyc=%0d got %b want %b", k, tx8_line, e);
      end
      n_cmp++;
      if (tx8_acp !== 1'b0) begin
        n_bad++; $display("FAIL tx_a5_acp_busy cyc=%0d got %b want 0", k, tx8_acp);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (tx8_acp !== 1'b1 || tx8_line !== 1'b1) begin
      n_bad++; $display("FAIL tx_a5_done got acp=%b tx=%b want 1 1", tx8_acp, tx8_line);
    end
    n_cmp++;
    if (wr8 != rd8) begin
      n_bad++; $display("FAIL tx_a5_rx_quiet got %0d nibbles want 0", wr8 - rd8);
    end
    tick(1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[3] = '{8'h00, 8'hFF, 8'h3C};
    logic [3:0] e, g;
    int e0 = err8, o0 = ovf8;
    loop8 = 1'b1;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      exp8.push_back(bytes[i][3:0]);
      exp8.push_back(bytes[i][7:4]);
      send8(bytes[i]);
    end
    wait_obs8(400);
    while (exp8.size() > 0) begin
      e = exp8.pop_front(); g = obs8[rd8 % 256]; rd8++;
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL loopback_nibble got %h want %h", g, e); end
    end
    tick(20);
    n_cmp++;
    if (wr8 != rd8 || err8 != e0 || ovf8 != o0) begin
      n_bad++; $display("FAIL loopback_extra got extra=%0d err=%0d ovf=%0d want 0 0 0", wr8 - rd8, err8 - e0, ovf8 - o0);
    end
  endtask

  task automatic test_frame_err();
    logic [3:0] e, g;
    int e0 = err8;
    loop8 = 1'b0;
    rx8_drv = 1'b1;
    tick(4);
    drive_rx8(8'h81, 1'b0);
    n_cmp++;
    if (err8 != e0 + 1) begin n_bad++; $display("FAIL frame_err_pulse got %0d want 1", err8 - e0); end
    n_cmp++;
    if (wr8 != rd8) begin n_bad++; $display("FAIL frame_err_novld got %0d nibbles want 0", wr8 - rd8); end
    exp8.push_back(4'h2);
    exp8.push_back(4'h4);
    drive_rx8(8'h42, 1'b1);
    wait_obs8(200);
    while (exp8.size() > 0) begin
      e = exp8.pop_front(); g = obs8[rd8 % 256]; rd8++;
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL frame_err_recover got %h want %h", g, e); end
    end
    n_cmp++;
    if (err8 != e0 + 1) begin n_bad++; $display("FAIL frame_err_count got %0d want 1", err8 - e0); end
  endtask

  task automatic test_false_start();
    logic [3:0] e, g;
    int e0 = err8, o0 = ovf8;
    loop8 = 1'b0;
    rx8_drv = 1'b0;
    tick(1);
    rx8_drv = 1'b1;
    tick(30);
    n_cmp++;
    if (wr8 != rd8 || err8 != e0 || ovf8 != o0) begin
      n_bad++; $display("FAIL false_start_quiet got vld=%0d err=%0d ovf=%0d want 0 0 0", wr8 - rd8, err8 - e0, ovf8 - o0);
    end
    exp8.push_back(4'hC);
    exp8.push_back(4'h3);
    drive_rx8(8'h3C, 1'b1);
    wait_obs8(200);
    while (exp8.size() > 0) begin
      e = exp8.pop_front(); g = obs8[rd8 % 256]; rd8++;
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL false_start_recover got %h want %h", g, e); end
    end
  endtask

  task automatic test_param16();
    logic [15:0] w = 16'h4321;
    logic e;
    logic [3:0] en, g;
    int e0 = err16, o0 = ovf16;
    for (int i = 0; i < 4; i++) exp16.push_back(w[i*4 +: 4]);
    send16(w);
    for (int k = 0; k < 38; k++) begin
      @(negedge clk);
      e = (k < 2) ? 1'b0 : (k < 34) ? w[k/2 - 1] : 1'b1;
      n_cmp++;
      if (tx16_line !== e || tx16_acp !== 1'b0) begin
        n_bad++; $display("FAIL p16_line cyc=%0d got tx=%b acp=%b want tx=%b acp=0", k, tx16_line, tx16_acp, e);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (tx16_acp !== 1'b1) begin n_bad++; $display("FAIL p16_acp_done got %b want 1", tx16_acp); end
    tick(1);
    wait_obs16(200);
    while (exp16.size() > 0) begin
      en = exp16.pop_front(); g = obs16[rd16 % 256]; rd16++;
      n_cmp++;
      if (g !== en) begin n_bad++; $display("FAIL p16_rx_nibble got %h want %h", g, en); end
    end
    tick(10);
    n_cmp++;
    if (wr16 != rd16 || err16 != e0 || ovf16 != o0) begin
      n_bad++; $display("FAIL p16_extra got vld=%0d err=%0d ovf=%0d want 0 0 0", wr16 - rd16, err16 - e0, ovf16 - o0);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] e, g;
    int e0 = err8, o0 = ovf8;
    loop8 = 1'b1;
    tick(2);
    send8(8'h96);
    tick(16);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tx8_line, tx8_acp, rx8_vld, rx8_err, rx8_ovf} !== 5'b11000) begin
      n_bad++; $display("FAIL reset_mid_outputs got %b want 11000", {tx8_line, tx8_acp, rx8_vld, rx8_err, rx8_ovf});
    end
    tick(2);
    rst_n = 1'b1;
    tick(40);
    n_cmp++;
    if (wr8 != rd8 || err8 != e0 || ovf8 != o0) begin
      n_bad++; $display("FAIL reset_mid_quiet got vld=%0d err=%0d ovf=%0d want 0 0 0", wr8 - rd8, err8 - e0, ovf8 - o0);
    end
    exp8.push_back(4'hA);
    exp8.push_back(4'h5);
    send8(8'h5A);
    wait_obs8(200);
    while (exp8.size() > 0) begin
      e = exp8.pop_front(); g = obs8[rd8 % 256]; rd8++;
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL reset_mid_recover got %h want %h", g, e); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    tx8_dat = 4'h0; tx8_vld = 1'b0; rx8_drv = 1'b1; loop8 = 1'b0;
    tx16_dat = 4'h0; tx16_vld = 1'b0;
    test_reset();
    test_tx_a5();
    test_back_to_back();
    test_frame_err();
    test_false_start();
    test_param16();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
